// File: rtl/mulalu.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mulalu                                                     |
// | Description : Iterative MULT/MULTU/DIV/DIVU unit in the EX stage. Owns   |
// |               the HI/LO registers and stalls IF..EX while an operation   |
// |               is in flight. Optional macro MULALU_FAST_MUL_EN replaces   |
// |               the 32-iteration shift-add multiply with a single-cycle    |
// |               32x32 multiply.                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_FUNC
`define W_FUNC 5
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 5'b00001
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b00010
`endif

module mulalu (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 valid,
    input  logic                 flush,
    input  logic [`W_FUNC-1:0]   mulalu_func,
    input  logic                 mulalu_sign,
    input  logic [`W_DATA-1:0]   source_a,
    input  logic [`W_DATA-1:0]   source_b,
    input  logic                 hi_write,
    input  logic                 lo_write,
    output logic [`W_DATA-1:0]   hi,
    output logic [`W_DATA-1:0]   lo,
    output logic                 stall
);

    localparam int         c_DW        = `W_DATA;
    localparam logic [5:0] c_LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_req;
    logic                w_issue;
    logic                w_finish;
    logic                w_last;

    // Operation context captured at issue
    logic [5:0]          r_count;
    logic [2*c_DW-1:0]   r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [c_DW-1:0]     r_mag_b;
    logic [c_DW-1:0]     r_src_a;    // raw dividend, returned in HI on divide by zero
    logic                r_is_div;
    logic                r_neg_q;    // product / quotient sign
    logic                r_neg_r;    // remainder sign
    logic                r_div_zero;

    // Issue-time magnitudes
    logic [c_DW-1:0]     w_mag_a;
    logic [c_DW-1:0]     w_mag_b;

    // One iteration of each algorithm
    logic [c_DW:0]       w_mul_sum;
    logic [2*c_DW-1:0]   w_mul_next;
    logic [c_DW:0]       w_div_shift;
    logic                w_div_ge;
    logic [c_DW:0]       w_div_rem;
    logic [2*c_DW-1:0]   w_div_next;
    logic [2*c_DW-1:0]   w_iter_next;
    logic [2*c_DW-1:0]   w_raw;

    // Sign-corrected results
    logic [2*c_DW-1:0]   w_prod_fix;
    logic [c_DW-1:0]     w_quo_fix;
    logic [c_DW-1:0]     w_rem_fix;
    logic [c_DW-1:0]     w_hi_res;
    logic [c_DW-1:0]     w_lo_res;

    assign w_req   = valid & ~flush & (mulalu_func != '0);
    assign w_mag_a = (mulalu_sign & source_a[c_DW-1]) ? -source_a : source_a;
    assign w_mag_b = (mulalu_sign & source_b[c_DW-1]) ? -source_b : source_b;

    // Shift-add: add multiplicand to the upper half when the multiplier LSB is set, then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*c_DW-1:c_DW]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[c_DW-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder, subtract if it fits
    assign w_div_shift = {r_acc[2*c_DW-1:c_DW], r_acc[c_DW-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
    assign w_div_rem   = w_div_ge ? (w_div_shift - {1'b0, r_mag_b}) : w_div_shift;
    assign w_div_next  = {w_div_rem[c_DW-1:0], r_acc[c_DW-2:0], w_div_ge};

    assign w_iter_next = r_is_div ? w_div_next : w_mul_next;

`ifdef MULALU_FAST_MUL_EN
    // The multiplicand magnitude still sits in the low half of the accumulator on the first BUSY cycle
    logic [2*c_DW-1:0]   w_fast_prod;
    assign w_fast_prod = {{c_DW{1'b0}}, r_acc[c_DW-1:0]} * {{c_DW{1'b0}}, r_mag_b};
    assign w_raw       = r_is_div ? w_iter_next : w_fast_prod;
    assign w_last      = (r_count == c_LAST_ITER) | ~r_is_div;
`else
    assign w_raw       = w_iter_next;
    assign w_last      = (r_count == c_LAST_ITER);
`endif

    assign w_prod_fix = r_neg_q ? -w_raw : w_raw;
    assign w_quo_fix  = r_neg_q ? -w_raw[c_DW-1:0] : w_raw[c_DW-1:0];
    assign w_rem_fix  = r_neg_r ? -w_raw[2*c_DW-1:c_DW] : w_raw[2*c_DW-1:c_DW];
    assign w_hi_res   = r_is_div ? (r_div_zero ? r_src_a : w_rem_fix) : w_prod_fix[2*c_DW-1:c_DW];
    assign w_lo_res   = r_is_div ? (r_div_zero ? {c_DW{1'b1}} : w_quo_fix) : w_prod_fix[c_DW-1:0];

    // State register: reset first, then flush aborts, then normal sequencing
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, issue/finish strobes and pipeline stall
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_issue     = 1'b1;
                    stall       = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (!flush && w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture at issue and one iteration per BUSY cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_mag_b    <= '0;
            r_src_a    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_issue) begin
            r_count    <= '0;
            r_acc      <= {{c_DW{1'b0}}, w_mag_a};
            r_mag_b    <= w_mag_b;
            r_src_a    <= source_a;
            r_is_div   <= (mulalu_func == `FUNC_DIV);
            r_neg_q    <= mulalu_sign & (source_a[c_DW-1] ^ source_b[c_DW-1]);
            r_neg_r    <= mulalu_sign & source_a[c_DW-1];
            r_div_zero <= (source_b == '0);
        end else if (r_state == S_BUSY && !flush) begin
            r_count    <= r_count + 6'd1;
            r_acc      <= w_iter_next;
        end
    end

    // HI/LO: result write on the last iteration, MTHI/MTLO only while idle and not flushed
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (w_finish) begin
            hi <= w_hi_res;
            lo <= w_lo_res;
        end else if (r_state == S_IDLE && !flush) begin
            if (hi_write) hi <= source_a;
            if (lo_write) lo <= source_a;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mulalu.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mulalu                                                  |
// | Description : Directed and random bench for mulalu; expected HI/LO are   |
// |               queued at issue and compared when the unit leaves BUSY.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef FUNC_MUL
`define FUNC_MUL 5'b00001
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b00010
`endif

module tb_mulalu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic        flush;
    logic [4:0]  mulalu_func;
    logic        mulalu_sign;
    logic [31:0] source_a;
    logic [31:0] source_b;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;

    always #5 clk = ~clk;

    mulalu dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (valid),
        .flush       (flush),
        .mulalu_func (mulalu_func),
        .mulalu_sign (mulalu_sign),
        .source_a    (source_a),
        .source_b    (source_b),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .hi          (hi),
        .lo          (lo),
        .stall       (stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    endtask

    // Reference behaviour for one MUL/DIV, returned as {HI, LO}
    function automatic logic [63:0] model(input logic is_div, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic [31:0] q;
        logic [31:0] m;
        if (!is_div) begin
            if (sgn) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else     r = {32'h0, a} * {32'h0, b};
        end else if (b == 32'h0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {32'h0, 32'h8000_0000};
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            m = $signed(a) % $signed(b);
            r = {m, q};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    task automatic idle_inputs();
        valid       = 1'b0;
        flush       = 1'b0;
        mulalu_func = 5'b0;
        mulalu_sign = 1'b0;
        hi_write    = 1'b0;
        lo_write    = 1'b0;
    endtask

    // Issue one operation, hold it in EX while stalled, then check latency and HI/LO in DONE
    task automatic run_op(input string tag, input logic is_div, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
        int          n;
        int          exp_stall;
        logic [63:0] want;
        exp_stall = 33;
`ifdef MULALU_FAST_MUL_EN
        if (!is_div) exp_stall = 2;
`endif
        sb_q.push_back(expv);
        @(negedge clk);
        valid       = 1'b1;
        flush       = 1'b0;
        hi_write    = 1'b0;
        lo_write    = 1'b0;
        mulalu_func = is_div ? `FUNC_DIV : `FUNC_MUL;
        mulalu_sign = sgn;
        source_a    = a;
        source_b    = b;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, ".stall_cycles"}, 64'(n), 64'(exp_stall));
        want = sb_q.pop_front();
        check({tag, ".hi"}, {32'h0, hi}, {32'h0, want[63:32]});
        check({tag, ".lo"}, {32'h0, lo}, {32'h0, want[31:0]});
        exp_hi = want[63:32];
        exp_lo = want[31:0];
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rs;
        logic        rd;
        logic [31:0] ra;
        logic [31:0] rb;

        resetn   = 1'b0;
        source_a = '0;
        source_b = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("reset.hi",    {32'h0, hi}, 64'h0);
        check("reset.lo",    {32'h0, lo}, 64'h0);
        check("reset.stall", {63'h0, stall}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed arithmetic
        run_op("mult_neg",  1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op("multu_b2b", 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, {32'h1, 32'h0});
        run_op("div_m7_2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_ovf",   1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        run_op("divu_by0",  1'b1, 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
        run_op("div_by0_s", 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
        run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});

        // MTHI, then a DIV flushed at BUSY iteration 10
        @(negedge clk);
        idle_inputs();
        valid    = 1'b1;
        hi_write = 1'b1;
        source_a = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        #1;
        check("mthi.hi", {32'h0, hi}, 64'h1234_5678);
        exp_hi = 32'h1234_5678;
        @(negedge clk);
        valid       = 1'b1;
        mulalu_func = `FUNC_DIV;
        mulalu_sign = 1'b1;
        source_a    = 32'd1000;
        source_b    = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        check("flush.stall", {63'h0, stall}, 64'h0);
        check("flush.hi",    {32'h0, hi}, {32'h0, exp_hi});
        check("flush.lo",    {32'h0, lo}, {32'h0, exp_lo});
        run_op("divu_after_flush", 1'b1, 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100});

        // Reset in the middle of a divide
        @(negedge clk);
        valid       = 1'b1;
        mulalu_func = `FUNC_DIV;
        mulalu_sign = 1'b0;
        source_a    = 32'h0000_FFFF;
        source_b    = 32'd3;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        check("midreset.hi",    {32'h0, hi}, 64'h0);
        check("midreset.lo",    {32'h0, lo}, 64'h0);
        check("midreset.stall", {63'h0, stall}, 64'h0);
        resetn = 1'b1;
        exp_hi = '0;
        exp_lo = '0;

        // MTLO under flush must not write; MTHI+MTLO together both write
        @(negedge clk);
        valid    = 1'b1;
        lo_write = 1'b1;
        flush    = 1'b1;
        source_a = 32'hDEAD_BEEF;
        @(negedge clk);
        idle_inputs();
        #1;
        check("mtlo_flush.lo", {32'h0, lo}, 64'h0);
        @(negedge clk);
        valid    = 1'b1;
        hi_write = 1'b1;
        lo_write = 1'b1;
        source_a = 32'hCAFE_F00D;
        @(negedge clk);
        idle_inputs();
        #1;
        check("mthilo.hi", {32'h0, hi}, 64'hCAFE_F00D);
        check("mthilo.lo", {32'h0, lo}, 64'hCAFE_F00D);

        // Random operations against the reference model
        for (int i = 0; i < 6; i++) begin
            rd = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i == 5) ? 32'($urandom_range(1, 255)) : $urandom;
            run_op($sformatf("rand%0d", i), rd, rs, ra, rb, model(rd, rs, ra, rb));
        end

        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mulalu.md
# mulalu

Multi-cycle multiply/divide unit in the EX stage, directly downstream of the single-cycle ALU. It consumes the ALU's `mulalu_func`/`mulalu_sign` decode and the EX operands, and runs MULT/MULTU/DIV/DIVU iteratively. It owns the architectural HI/LO registers, returns them to the ALU for MFHI/MFLO, and stalls the pipeline while an operation is in flight.

## Interface
Parameters:
- none. Widths come from the `W_DATA` and `W_FUNC` include macros.

Ports:
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  synchronous, active-low reset.
- `valid`  in  1  EX holds a live instruction that may issue.
- `flush`  in  1  exception flush. Kills the EX instruction.
- `mulalu_func`  in  `W_FUNC`  `FUNC_MUL`, `FUNC_DIV`, or 5'b00000 (no operation).
- `mulalu_sign`  in  1  1 = signed, 0 = unsigned.
- `source_a`  in  `W_DATA`  multiplicand / dividend. Also the MTHI/MTLO write data.
- `source_b`  in  `W_DATA`  multiplier / divisor.
- `hi_write`  in  1  MTHI: write HI from `source_a`.
- `lo_write`  in  1  MTLO: write LO from `source_a`.
- `hi`  out  `W_DATA`  HI register.
- `lo`  out  `W_DATA`  LO register.
- `stall`  out  1  freeze IF..EX while asserted.

## Operation
- **Request:** `req = valid & ~flush & (mulalu_func != 0)`.
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - On `req`: latch operand magnitudes and the result signs (product/quotient sign = a[31]^b[31] when signed; remainder sign = a[31]), clear the counter, go to BUSY.
- **BUSY:** one iteration per cycle, 6-bit counter.
  - Multiply: shift-add on magnitudes.
  - Divide: restoring divide on magnitudes.
  - After the last iteration: sign-correct, write HI/LO, go to DONE.
- **DONE:**
  - Lasts one cycle. `req` is ignored here, because it comes from the same instruction leaving EX.
  - Next state is IDLE.
- **Results:**
  - MULT/MULTU: {HI, LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- **Divide by zero:** HI = `source_a`, LO = 32'hFFFFFFFF, with or without sign. The full iteration count still runs.
- **Signed 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0.
- **MTHI/MTLO:** write `source_a` into HI or LO at the clock edge, only in IDLE and only when `flush` = 0. Both may be written in the same cycle.
- **Flush:** `flush` in BUSY forces IDLE on the next edge. HI/LO stay unchanged.
- **Precedence:** reset > flush > FSM.

## Timing
- **Reset values:** `hi` = 0, `lo` = 0, `stall` = 0, state = IDLE, counter = 0.
- **`stall`** (combinational) = `(IDLE & req) | BUSY`. It is 0 in DONE.
- **Divide latency:**
  - Cycle 0: IDLE issue.
  - Cycles 1..32: BUSY.
  - HI/LO are written at the edge ending cycle 32.
  - Cycle 33: DONE, `stall` = 0, and the instruction leaves EX at the end of that cycle.
  - `stall` is high for 33 cycles.
- **Multiply latency:** same as divide without fast multiply; one BUSY cycle with fast multiply (see Configuration).
- **HI/LO visibility:** the new values are visible on `hi`/`lo` from cycle 33. The following instruction's MFHI/MFLO reads the updated value with no bypass.
- **Back-to-back operations:** a second MUL/DIV reaching EX the cycle after DONE issues normally from IDLE.
- **`resetn` low mid-operation:** aborts at the next edge and restores all reset values.

## Configuration
- **`MULALU_FAST_MUL_EN` defined:**
  - Multiply is one 32x32 multiply plus sign correction, computed in a single BUSY cycle.
  - Multiply latency is 3 cycles with `stall` high for 2.
  - Divide is unchanged.
- **`MULALU_FAST_MUL_EN` undefined:** multiply uses the 32-iteration shift-add path, with the same timing as divide.

## Test plan
- **Signed multiply:** MULT 0xFFFFFFFE × 0x00000003 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. `stall` high 33 cycles (2 with `MULALU_FAST_MUL_EN`).
- **Unsigned divide:** DIVU 100 / 7 -> LO = 14, HI = 2. `stall` drops in cycle 33. A back-to-back MULTU 0x10000 × 0x10000 -> HI = 1, LO = 0.
- **Signed divide and corner case:**
  - DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU 5 / 0 -> HI = 5, LO = 0xFFFFFFFF after the full latency.
- **Flush mid-operation:** MTHI 0x12345678, then DIV, with `flush` asserted at BUSY iteration 10 -> HI = 0x12345678 and LO unchanged, `stall` = 0 the next cycle, and a following DIVU issues normally.
- **Reset and MTHI/MTLO behaviour:**
  - Assert `resetn` = 0 mid-divide -> HI/LO = 0 and `stall` = 0 at the next edge.
  - MTLO together with `flush` -> LO is not written.
